// File: rtl/stack_pkg.sv
// Shared defaults and the pop-sequencer state encoding for the return-stack pop unit.
package stack_pkg;

    localparam int ADDR_W_DEF = 12;
    localparam int DEPTH_DEF  = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } pop_state_e;

endpackage

// File: rtl/stack_depth_ctr.sv
// Stack occupancy counter with full/empty status and a sticky overflow flag.
module stack_depth_ctr #(
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    output logic [CNT_W-1:0] depth,
    output logic             empty,
    output logic             full,
    output logic             overflow
);

    logic push_acc;

    assign empty    = (depth == '0);
    assign full     = (depth == CNT_W'(DEPTH));
    assign push_acc = push && !full;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            depth    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push && full) begin
                overflow <= 1'b1;
            end
            // a push and a pop in the same cycle cancel out
            case ({push_acc, pop})
                2'b10:   depth <= depth + CNT_W'(1);
                2'b01:   depth <= depth - CNT_W'(1);
                default: depth <= depth;
            endcase
        end
    end

endmodule

// File: rtl/stack_pop_unit.sv
// Return-stack pop sequencer: reads the top entry through registered storage and pops it.
// Optional STACK_UNDERFLOW_ERR_EN adds a sticky underflow flag and a zero-address error response.
//
// state | meaning
// IDLE  | waiting for ret_req; rd_idx follows the current top of stack
// ADDR  | latched idx presented on rd_idx
// WAIT  | storage read data arriving; captured into ret_addr at the exit edge
// DONE  | ret_valid and pop asserted for this single cycle
module stack_pop_unit
    import stack_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DEPTH  = DEPTH_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     ret_req,
    input  logic                     push,
    input  logic [ADDR_W-1:0]        rd_data,
    output logic [$clog2(DEPTH)-1:0] rd_idx,
    output logic                     pop,
    output logic                     ret_valid,
    output logic [ADDR_W-1:0]        ret_addr,
`ifdef STACK_UNDERFLOW_ERR_EN
    output logic                     underflow,
`endif
    output logic                     busy,
    output logic                     empty,
    output logic                     full,
    output logic                     overflow
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    pop_state_e       state;
    pop_state_e       state_nxt;
    logic [IDX_W-1:0] idx;
    logic [IDX_W-1:0] top_idx;
    logic [CNT_W-1:0] depth;
    logic             start;

    stack_depth_ctr #(
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) u_depth (
        .clk      (clk),
        .rst      (rst),
        .push     (push),
        .pop      (pop),
        .depth    (depth),
        .empty    (empty),
        .full     (full),
        .overflow (overflow)
    );

    // wraps to DEPTH-1 when the stack is empty
    assign top_idx = IDX_W'(depth - CNT_W'(1));
    assign start   = (state == IDLE) && ret_req && !empty;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = ADDR;
            ADDR:    state_nxt = WAIT;
            WAIT:    state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

`ifdef STACK_UNDERFLOW_ERR_EN
    logic uf_hit;
    logic uf_pulse;

    assign uf_hit = (state == IDLE) && ret_req && empty;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            idx      <= '0;
            ret_addr <= '0;
`ifdef STACK_UNDERFLOW_ERR_EN
            uf_pulse  <= 1'b0;
            underflow <= 1'b0;
`endif
        end else begin
            state <= state_nxt;
            if (start) begin
                idx <= top_idx;
            end
            if (state == WAIT) begin
                ret_addr <= rd_data;
            end
`ifdef STACK_UNDERFLOW_ERR_EN
            uf_pulse <= uf_hit;
            if (uf_hit) begin
                underflow <= 1'b1;
                ret_addr  <= '0;
            end
`endif
        end
    end

    assign busy   = (state != IDLE);
    assign pop    = (state == DONE);
    assign rd_idx = ((state == ADDR) || (state == WAIT)) ? idx : top_idx;

`ifdef STACK_UNDERFLOW_ERR_EN
    assign ret_valid = (state == DONE) || uf_pulse;
`else
    assign ret_valid = (state == DONE);
`endif

endmodule
